// File: rtl/ram_arb_pkg.sv
// Shared definitions for the arbitrated memory unit: default word/address
// widths, the controller state encoding and an index-width helper.
package ram_arb_pkg;

    localparam int MEMORY_ADDR_WIDTH = 10;
    localparam int MEMORY_DATA_WIDTH = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_t;

    // Width of an index into n items; never zero so single-item cases stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, priority pointer moves
// past the winner after every grant and holds when nothing is granted.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = idx_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    int            j;

    // Scan downward from the farthest slot so the closest requester to ptr wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = PW'(j);
            end
        end
    end

    // Priority pointer: next port after the winner becomes highest priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Arbitrated single-port RAM: round-robin access for NUM_PORTS requesters,
// optional extra read register, out-of-range flagging and a post-reset
// clear engine that zeroes the array before any request is granted.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_CLEAR | writing zero to word clear_cnt each cycle, no grants
//   ST_RUN   | init_done high, arbiter grants one request per cycle
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = MEMORY_ADDR_WIDTH,
    parameter int DATA_WIDTH     = MEMORY_DATA_WIDTH,
    parameter int DEPTH          = 1024,
    parameter int NUM_PORTS      = 2,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_wren,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data,
    output logic                            init_done,
    output logic                            addr_err
);

    localparam int PW = idx_width(NUM_PORTS);
    localparam int CW = idx_width(DEPTH);

    mem_state_t             state;
    logic [CW-1:0]          clear_cnt;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [NUM_PORTS-1:0]   arb_req;
    logic [NUM_PORTS-1:0]   grant;
    logic [PW-1:0]          sel;
    logic                   acc;
    logic                   acc_wren;
    logic                   acc_rd;
    logic                   in_range;
    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic [DATA_WIDTH-1:0]  acc_data;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic                   fin_valid;
    logic [PW-1:0]          fin_port;
    logic [DATA_WIDTH-1:0]  fin_data;

    assign arb_req   = req_valid & {NUM_PORTS{state == ST_RUN}};
    assign req_ready = grant;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (arb_req),
        .grant   (grant)
    );

    // Encode the one-hot grant into the winning port index.
    always_comb begin
        sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) sel = PW'(p);
        end
    end

    assign acc      = |grant;
    assign acc_wren = req_wren[sel];
    assign acc_rd   = acc & ~acc_wren;
    assign acc_addr = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign acc_data = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
    assign in_range = {1'b0, acc_addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign rd_word  = in_range ? mem[acc_addr[CW-1:0]] : '0;

    // Single write port shared by the clear engine and accepted writes.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[clear_cnt] <= '0;
        end else if (acc && acc_wren && in_range) begin
            mem[acc_addr[CW-1:0]] <= acc_data;
        end
    end

    // Controller: sweep the clear counter once, then stay in RUN until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clear_cnt <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_cnt == CW'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
                ST_RUN: init_done <= 1'b1;
            endcase
        end
    end

    // Sticky flag for any accepted request outside the array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (acc && !in_range) begin
            addr_err <= 1'b1;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  p_valid;
            logic [PW-1:0]         p_port;
            logic [DATA_WIDTH-1:0] p_data;

            // Extra stage between the array and the response registers.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    p_valid <= 1'b0;
                    p_port  <= '0;
                    p_data  <= '0;
                end else begin
                    p_valid <= acc_rd;
                    if (acc_rd) begin
                        p_port <= sel;
                        p_data <= rd_word;
                    end
                end
            end

            assign fin_valid = p_valid;
            assign fin_port  = p_port;
            assign fin_data  = p_data;
        end else begin : g_lat1
            assign fin_valid = acc_rd;
            assign fin_port  = sel;
            assign fin_data  = rd_word;
        end
    endgenerate

    // Response registers: one-cycle strobe, data slice held until next read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (fin_valid) begin
                rsp_valid[fin_port]                          <= 1'b1;
                rsp_data[fin_port*DATA_WIDTH +: DATA_WIDTH] <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: instance A (DEPTH=16, latency 1) and instance B
// (DEPTH=768, latency 2) checked against a plain array/pointer model.
module tb_ram_arb;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        a_rst_n, b_rst_n;
    logic [1:0]  a_valid, a_ready, a_wren, a_rv;
    logic [9:0]  a_addr;
    logic [23:0] a_data, a_rd;
    logic        a_done, a_err;
    logic [1:0]  b_valid, b_ready, b_wren, b_rv;
    logic [19:0] b_addr;
    logic [23:0] b_data, b_rd;
    logic        b_done, b_err;

    int          passed = 0;
    int          total  = 0;
    int unsigned ma [16];
    int          a_ptr, b_ptr;
    bit          a_errm;

    ram_arb #(.ADDR_WIDTH(5), .DATA_WIDTH(12), .DEPTH(16), .NUM_PORTS(2),
              .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
        .clock(clock), .reset_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_wren(a_wren), .req_addr(a_addr), .req_data(a_data), .rsp_valid(a_rv),
        .rsp_data(a_rd), .init_done(a_done), .addr_err(a_err));

    ram_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(12), .DEPTH(768), .NUM_PORTS(2),
              .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clock(clock), .reset_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_wren(b_wren), .req_addr(b_addr), .req_data(b_data), .rsp_valid(b_rv),
        .rsp_data(b_rd), .init_done(b_done), .addr_err(b_err));

    // Round-robin rule: first valid port starting at the priority pointer.
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input int ptr);
        logic [1:0] g = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (v[(ptr + i) % 2] && g == 2'b00) g[(ptr + i) % 2] = 1'b1;
        end
        return g;
    endfunction

    task automatic a_set(input int p, input bit v, input bit w, input int ad, input int d);
        a_valid[p]         = v;
        a_wren[p]          = w;
        a_addr[p*5 +: 5]   = 5'(ad);
        a_data[p*12 +: 12] = 12'(d);
    endtask

    task automatic b_set(input int p, input bit v, input bit w, input int ad, input int d);
        b_valid[p]         = v;
        b_wren[p]          = w;
        b_addr[p*10 +: 10] = 10'(ad);
        b_data[p*12 +: 12] = 12'(d);
    endtask

    task automatic a_model_reset();
        for (int i = 0; i < 16; i++) ma[i] = 0;
        a_ptr  = 0;
        a_errm = 0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        a_set(0, 1, 0, 5, 0);
        repeat (2) @(negedge clock);
        #1;
        total++; if (a_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", a_ready); else passed++;
        total++; if (a_rv !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", a_rv); else passed++;
        total++; if (a_rd !== 24'h0) $display("FAIL reset_rsp_data got %h want 0", a_rd); else passed++;
        total++; if (a_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", a_done); else passed++;
        total++; if (a_err !== 1'b0) $display("FAIL reset_addr_err got %b want 0", a_err); else passed++;
        a_valid = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_clear();
        int n = 0;
        a_rst_n = 1'b1;
        a_model_reset();
        while (!a_done && n < 40) begin @(negedge clock); n++; end
        total++; if (a_done !== 1'b1) $display("FAIL clear_first_done got %b want 1", a_done); else passed++;
        for (int c = 0; c < 16; c++) begin
            a_set(0, 1, 1, c, 'h5A0 + c);
            #1;
            total++; if (a_ready !== 2'b01) $display("FAIL fill_ready addr %0d got %b want 01", c, a_ready); else passed++;
            @(negedge clock);
        end
        a_valid = 2'b00;
        a_rst_n = 1'b0;
        @(negedge clock);
        a_set(0, 1, 0, 5, 0);
        a_rst_n = 1'b1;
        a_model_reset();
        for (int c = 0; c < 16; c++) begin
            #1;
            total++;
            if ({a_done, a_ready} !== 3'b000) $display("FAIL clear_busy cycle %0d got done %b ready %b want 0 00", c, a_done, a_ready);
            else passed++;
            @(negedge clock);
        end
        #1;
        total++; if (a_done !== 1'b1) $display("FAIL clear_done got %b want 1", a_done); else passed++;
        total++; if (a_ready !== 2'b01) $display("FAIL clear_first_grant got %b want 01", a_ready); else passed++;
        a_ptr = 1;
        @(negedge clock);
        a_valid = 2'b00;
        total++; if (a_rv !== 2'b01) $display("FAIL clear_read_valid got %b want 01", a_rv); else passed++;
        total++; if (a_rd[11:0] !== 12'h000) $display("FAIL clear_read_data got %h want 000", a_rd[11:0]); else passed++;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        a_set(0, 1, 1, 3, 'hABC);
        #1;
        total++; if (a_ready !== 2'b01) $display("FAIL wr_ready got %b want 01", a_ready); else passed++;
        @(negedge clock);
        ma[3] = 'hABC; a_ptr = 1;
        a_set(0, 1, 0, 3, 0);
        #1;
        total++; if (a_ready !== 2'b01) $display("FAIL rd_ready got %b want 01", a_ready); else passed++;
        total++; if (a_rv !== 2'b00) $display("FAIL wr_no_response got %b want 00", a_rv); else passed++;
        @(negedge clock);
        a_valid = 2'b00;
        total++; if (a_rv !== 2'b01) $display("FAIL rd_valid got %b want 01", a_rv); else passed++;
        total++; if (a_rd[11:0] !== 12'hABC) $display("FAIL rd_data got %h want abc", a_rd[11:0]); else passed++;
        @(negedge clock);
        total++; if (a_rv !== 2'b00) $display("FAIL rd_pulse_width got %b want 00", a_rv); else passed++;
    endtask

    task automatic test_alternate();
        logic [1:0] g, prev;
        int         addr_of [2];
        addr_of[0] = 3; addr_of[1] = 6;
        a_set(1, 1, 1, 6, 'h666);
        #1;
        total++; if (a_ready !== 2'b10) $display("FAIL alt_lone_ready got %b want 10", a_ready); else passed++;
        @(negedge clock);
        ma[6] = 'h666; a_ptr = 0;
        a_set(0, 1, 0, 3, 0);
        a_set(1, 1, 0, 6, 0);
        prev = 2'b00;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) a_valid = 2'b00;
            #1;
            g = (c == 8) ? 2'b00 : rr_pick(2'b11, a_ptr);
            total++; if (a_ready !== g) $display("FAIL alt_ready cycle %0d got %b want %b", c, a_ready, g); else passed++;
            total++; if (a_rv !== prev) $display("FAIL alt_rsp_valid cycle %0d got %b want %b", c, a_rv, prev); else passed++;
            for (int p = 0; p < 2; p++) begin
                if (prev[p]) begin
                    total++;
                    if (a_rd[p*12 +: 12] !== 12'(ma[addr_of[p]]))
                        $display("FAIL alt_rsp_data port %0d got %h want %h", p, a_rd[p*12 +: 12], 12'(ma[addr_of[p]]));
                    else passed++;
                end
            end
            if (g[0]) a_ptr = 1; else if (g[1]) a_ptr = 0;
            prev = g;
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        logic [1:0] pv, pw, g, exp_rv;
        int         pa [2];
        int         pd [2];
        int         rp, exp_val;
        pv = 2'b00; pw = 2'b00; exp_rv = 2'b00; rp = 0; exp_val = 0;
        for (int c = 0; c < 300; c++) begin
            total++; if (a_rv !== exp_rv) $display("FAIL rand_rsp_valid cycle %0d got %b want %b", c, a_rv, exp_rv); else passed++;
            if (exp_rv != 2'b00) begin
                total++;
                if (a_rd[rp*12 +: 12] !== 12'(exp_val))
                    $display("FAIL rand_rsp_data cycle %0d port %0d got %h want %h", c, rp, a_rd[rp*12 +: 12], 12'(exp_val));
                else passed++;
            end
            total++; if (a_err !== a_errm) $display("FAIL rand_addr_err cycle %0d got %b want %b", c, a_err, a_errm); else passed++;
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 9) < 6) begin
                    pv[p] = 1'b1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = $urandom_range(0, (c < 200) ? 15 : 19);
                    pd[p] = $urandom_range(0, 4095);
                end
                a_set(p, pv[p], pw[p], pa[p], pd[p]);
            end
            #1;
            g = rr_pick(pv, a_ptr);
            total++; if (a_ready !== g) $display("FAIL rand_ready cycle %0d got %b want %b", c, a_ready, g); else passed++;
            exp_rv = 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (g[p]) begin
                    if (pa[p] >= 16) a_errm = 1;
                    if (pw[p]) begin
                        if (pa[p] < 16) ma[pa[p]] = pd[p];
                    end else begin
                        exp_rv[p] = 1'b1;
                        rp        = p;
                        exp_val   = (pa[p] < 16) ? int'(ma[pa[p]]) : 0;
                    end
                    pv[p] = 1'b0;
                    a_ptr = (p + 1) % 2;
                end
            end
            @(negedge clock);
        end
        a_valid = 2'b00;
        total++; if (a_rv !== exp_rv) $display("FAIL rand_last_valid got %b want %b", a_rv, exp_rv); else passed++;
        @(negedge clock);
    endtask

    task automatic test_reset_midclear();
        a_set(0, 1, 0, 15, 0);
        #2 a_rst_n = 1'b0;
        #1;
        total++; if ({a_done, a_ready, a_rv} !== 5'b0) $display("FAIL async_reset got done %b ready %b rv %b want 0", a_done, a_ready, a_rv); else passed++;
        total++; if (a_err !== 1'b0) $display("FAIL async_reset_err got %b want 0", a_err); else passed++;
        @(negedge clock);
        a_rst_n = 1'b1;
        repeat (7) @(negedge clock);
        a_rst_n = 1'b0;
        @(negedge clock);
        a_rst_n = 1'b1;
        a_model_reset();
        for (int c = 0; c < 16; c++) begin
            #1;
            total++;
            if ({a_done, a_ready} !== 3'b000) $display("FAIL reclear_busy cycle %0d got done %b ready %b want 0 00", c, a_done, a_ready);
            else passed++;
            @(negedge clock);
        end
        #1;
        total++; if (a_done !== 1'b1) $display("FAIL reclear_done got %b want 1", a_done); else passed++;
        @(negedge clock);
        a_valid = 2'b00;
        total++; if (a_rv !== 2'b01) $display("FAIL reclear_read_valid got %b want 01", a_rv); else passed++;
        total++; if (a_rd[11:0] !== 12'h000) $display("FAIL reclear_read_data got %h want 000", a_rd[11:0]); else passed++;
        @(negedge clock);
    endtask

    task automatic test_latency2();
        int n = 0;
        while (!b_done && n < 1000) begin @(negedge clock); n++; end
        total++; if (b_done !== 1'b1) $display("FAIL b_init_done got %b want 1", b_done); else passed++;
        b_ptr = 0;
        b_set(0, 1, 1, 3, 'hABC);
        #1;
        total++; if (b_ready !== rr_pick(2'b01, b_ptr)) $display("FAIL lat2_wr_ready got %b want 01", b_ready); else passed++;
        b_ptr = 1;
        @(negedge clock);
        b_set(0, 1, 0, 3, 0);
        #1;
        total++; if (b_ready !== 2'b01) $display("FAIL lat2_rd_ready got %b want 01", b_ready); else passed++;
        @(negedge clock);
        b_valid = 2'b00;
        total++; if (b_rv !== 2'b00) $display("FAIL lat2_early got %b want 00", b_rv); else passed++;
        @(negedge clock);
        total++; if (b_rv !== 2'b01) $display("FAIL lat2_valid got %b want 01", b_rv); else passed++;
        total++; if (b_rd[11:0] !== 12'hABC) $display("FAIL lat2_data got %h want abc", b_rd[11:0]); else passed++;
        @(negedge clock);
        total++; if (b_rv !== 2'b00) $display("FAIL lat2_pulse got %b want 00", b_rv); else passed++;
    endtask

    task automatic test_out_of_range();
        int          rd_addr [4];
        int unsigned rd_exp  [4];
        rd_addr[0] = 10;  rd_exp[0] = 'h5A5;
        rd_addr[1] = 800; rd_exp[1] = 0;
        rd_addr[2] = 132; rd_exp[2] = 0;
        rd_addr[3] = 388; rd_exp[3] = 0;
        total++; if (b_err !== 1'b0) $display("FAIL oor_err_before got %b want 0", b_err); else passed++;
        b_set(1, 1, 1, 10, 'h5A5);
        #1; @(negedge clock);
        b_set(0, 1, 1, 900, 'h777);
        b_valid[1] = 1'b0;
        #1;
        total++; if (b_ready !== 2'b01) $display("FAIL oor_wr_ready got %b want 01", b_ready); else passed++;
        @(negedge clock);
        b_valid = 2'b00;
        total++; if (b_err !== 1'b1) $display("FAIL oor_wr_err got %b want 1", b_err); else passed++;
        for (int k = 0; k < 4; k++) begin
            b_set(1, 1, 0, rd_addr[k], 0);
            #1;
            total++; if (b_ready !== 2'b10) $display("FAIL oor_rd_ready addr %0d got %b want 10", rd_addr[k], b_ready); else passed++;
            @(negedge clock);
            b_valid = 2'b00;
            @(negedge clock);
            total++; if (b_rv !== 2'b10) $display("FAIL oor_rd_valid addr %0d got %b want 10", rd_addr[k], b_rv); else passed++;
            total++;
            if (b_rd[23:12] !== 12'(rd_exp[k])) $display("FAIL oor_rd_data addr %0d got %h want %h", rd_addr[k], b_rd[23:12], 12'(rd_exp[k]));
            else passed++;
        end
        repeat (3) @(negedge clock);
        total++; if (b_err !== 1'b1) $display("FAIL oor_err_sticky got %b want 1", b_err); else passed++;
    endtask

    task automatic test_reset_inflight();
        b_set(0, 1, 0, 3, 0);
        @(posedge clock);
        #2 b_rst_n = 1'b0;
        b_valid = 2'b00;
        #2 b_rst_n = 1'b1;
        @(negedge clock);
        total++; if (b_rv !== 2'b00) $display("FAIL inflight_valid0 got %b want 00", b_rv); else passed++;
        total++; if (b_done !== 1'b0) $display("FAIL inflight_done got %b want 0", b_done); else passed++;
        @(negedge clock);
        total++; if (b_rv !== 2'b00) $display("FAIL inflight_valid1 got %b want 00", b_rv); else passed++;
        total++; if (b_rd !== 24'h0) $display("FAIL inflight_data got %h want 0", b_rd); else passed++;
        total++; if (b_err !== 1'b0) $display("FAIL inflight_err got %b want 0", b_err); else passed++;
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_valid = '0; a_wren = '0; a_addr = '0; a_data = '0;
        b_valid = '0; b_wren = '0; b_addr = '0; b_data = '0;
        a_model_reset();
        b_ptr = 0;
        @(negedge clock);
        b_rst_n = 1'b1;
        test_reset();
        test_clear();
        test_write_read();
        test_alternate();
        test_random();
        test_reset_midclear();
        test_latency2();
        test_out_of_range();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
